// File: rtl/vnlp_gen2.sv
// ============================================================================
// Module   : vnlp_gen2
// Summary  : Walks a linked list of DIM-element signed vectors in memory and
//            accumulates a saturating L2^2 or L1 norm over every element.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vnlp_gen2 #(
    parameter int WORD_SIZE = 24,
    parameter int ADDR_BITS = 9,
    parameter int DIM       = 2,
    parameter int LEN_SIZE  = 8,
    parameter int PRECIS    = 56,
    parameter int NULL_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] head,
    input  logic                 mode,
    output logic                 busy,
    output logic                 done,
    output logic [PRECIS-1:0]    norm,
    output logic [LEN_SIZE-1:0]  len,
    output logic                 ovf,
    output logic                 err,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_valid
);

    localparam int C_TW = 2 * WORD_SIZE;
    localparam int C_SW = ((PRECIS > C_TW) ? PRECIS : C_TW) + 1;
    localparam int C_KW = $clog2(DIM + 1);

    localparam logic [ADDR_BITS-1:0] C_NULL     = ADDR_BITS'(NULL_ADDR);
    localparam logic [LEN_SIZE-1:0]  C_LEN_MAX  = '1;
    localparam logic [C_KW-1:0]      C_DIM      = C_KW'(DIM);
    localparam logic [C_SW-1:0]      C_NORM_MAX = {{(C_SW-PRECIS){1'b0}}, {PRECIS{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH_PTR  = 2'd1,
        S_FETCH_ELEM = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_base;
    logic [ADDR_BITS-1:0] r_next;
    logic [C_KW-1:0]      r_k;
    logic                 r_mode;
    logic [PRECIS-1:0]    r_norm;
    logic [LEN_SIZE-1:0]  r_len;
    logic                 r_ovf;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_mem_req;
    logic [ADDR_BITS-1:0] r_mem_addr;

    logic [WORD_SIZE-1:0] w_mag;
    logic [C_TW-1:0]      w_sq;
    logic [C_TW-1:0]      w_term;
    logic [C_SW-1:0]      w_sum;
    logic                 w_sat;
    logic [LEN_SIZE-1:0]  w_len_inc;
    logic [ADDR_BITS-1:0] w_elem_addr_next;

    // Two's-complement negate taken as unsigned, so the most negative value
    // maps to 2^(WORD_SIZE-1) instead of overflowing.
    assign w_mag  = mem_rdata[WORD_SIZE-1] ? (WORD_SIZE'(0) - mem_rdata) : mem_rdata;
    assign w_sq   = C_TW'(w_mag) * C_TW'(w_mag);
    assign w_term = r_mode ? C_TW'(w_mag) : w_sq;
    assign w_sum  = C_SW'(r_norm) + C_SW'(w_term);
    assign w_sat  = r_ovf | (w_sum > C_NORM_MAX);

    assign w_len_inc        = r_len + LEN_SIZE'(1);
    assign w_elem_addr_next = r_base + ADDR_BITS'(r_k) + ADDR_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_next     <= '0;
            r_k        <= '0;
            r_mode     <= 1'b0;
            r_norm     <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_norm <= '0;
                        r_len  <= '0;
                        r_ovf  <= 1'b0;
                        r_err  <= 1'b0;
                        r_mode <= mode;
                        r_base <= head;
                        r_busy <= 1'b1;
                        if (head == C_NULL) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH_PTR;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= head;
                        end
                    end
                end

                S_FETCH_PTR: begin
                    if (mem_valid) begin
                        r_next     <= mem_rdata[ADDR_BITS-1:0];
                        r_k        <= C_KW'(1);
                        r_mem_addr <= r_base + ADDR_BITS'(1);
                        r_state    <= S_FETCH_ELEM;
                    end
                end

                S_FETCH_ELEM: begin
                    if (mem_valid) begin
                        r_norm <= w_sat ? C_NORM_MAX[PRECIS-1:0] : w_sum[PRECIS-1:0];
                        r_ovf  <= w_sat;
                        if (r_k < C_DIM) begin
                            r_k        <= r_k + C_KW'(1);
                            r_mem_addr <= w_elem_addr_next;
                        end else begin
                            r_len <= w_len_inc;
                            // The length guard catches both cyclic and over-long lists.
                            if (r_next == C_NULL) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_mem_req <= 1'b0;
                            end else if (w_len_inc == C_LEN_MAX) begin
                                r_err     <= 1'b1;
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_mem_req <= 1'b0;
                            end else begin
                                r_base     <= r_next;
                                r_mem_addr <= r_next;
                                r_state    <= S_FETCH_PTR;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign norm     = r_norm;
    assign len      = r_len;
    assign ovf      = r_ovf;
    assign err      = r_err;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

endmodule

`default_nettype wire
